// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Register map, CTRL/STATUS bit positions and transmitter FSM
//                encoding shared by the uart_tx_fifo block.
//                Optional parity support: define UART_TX_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    // Word offsets, decoded from PADDR[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_PAR_BIT     = 1;
    localparam int CTRL_IE_BIT      = 2;
    localparam int CTRL_THRESH_LSB  = 8;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_EMPTY_BIT   = 1;
    localparam int STAT_FULL_BIT    = 2;
    localparam int STAT_OVF_BIT     = 3;
    localparam int STAT_LEVEL_LSB   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // A divisor of zero behaves as one cycle per bit
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sync_fifo
//  Description : Single-clock FIFO with occupancy count; a push while full is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : APB-programmed UART transmitter with transmit FIFO, baud
//                divisor, level interrupt. Parity: define UART_TX_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RST    = 16'd52
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        UARTTXD,
    output logic        TXINTR
);

    localparam int         LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

    logic [1:0]        addr;
    logic              wr_en;
    logic              unused_paddr;

    logic [15:0]       div_q, div_d;
    logic [7:0]        thresh_q, thresh_d;
    logic              ie_q, ie_d;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic              odd_q, odd_d;
    logic              par_q, par_d;
`endif

    tx_state_e         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              boundary;
    logic              busy;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic [8:0]        level_x;
    logic [7:0]        level_rd;

    assign addr         = PADDR[3:2];
    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign unused_paddr = ^{PADDR[11:4], PADDR[1:0]};

    uart_tx_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push),
        .wdata (PWDATA[DATA_W-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Register file next-state
    always_comb begin
        div_d    = div_q;
        thresh_d = thresh_q;
        ie_d     = ie_q;
        en_d     = en_q;
        ovf_d    = ovf_q;
`ifdef UART_TX_PARITY_EN
        odd_d    = odd_q;
`endif
        push     = 1'b0;
        if (wr_en) begin
            case (addr)
                ADDR_DATA: begin
                    push = 1'b1;
                    if (full & ~pop) ovf_d = 1'b1;
                end
                ADDR_DIV: div_d = PWDATA;
                ADDR_CTRL: begin
                    thresh_d = PWDATA[CTRL_THRESH_LSB +: 8];
                    ie_d     = PWDATA[CTRL_IE_BIT];
                    en_d     = PWDATA[CTRL_EN_BIT];
`ifdef UART_TX_PARITY_EN
                    odd_d    = PWDATA[CTRL_PAR_BIT];
`endif
                end
                default: begin
                    if (PWDATA[STAT_OVF_BIT]) ovf_d = 1'b0;
                end
            endcase
        end
    end

    // Transmitter next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        pop      = 1'b0;
        boundary = (cnt_q == 16'd0);

        case (state_q)
            ST_IDLE: begin
                if (en_q & ~empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (boundary) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (boundary) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (boundary) begin
                    if (en_q & ~empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = (^fifo_rdata) ^ odd_q;
`endif
        end

        // The divisor is sampled only here, so mid-bit writes apply to the next bit
        if (pop || (state_q != ST_IDLE && boundary)) begin
            cnt_d = bit_reload(div_q);
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_q    <= DIV_RST;
            thresh_q <= 8'd0;
            ie_q     <= 1'b0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            odd_q    <= 1'b0;
            par_q    <= 1'b0;
`endif
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= '0;
        end else begin
            div_q    <= div_d;
            thresh_q <= thresh_d;
            ie_q     <= ie_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
            odd_q    <= odd_d;
            par_q    <= par_d;
`endif
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
        end
    end

    // Serial line and busy decode
    always_comb begin
        UARTTXD = 1'b1;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_START:  UARTTXD = 1'b0;
            ST_DATA:   UARTTXD = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: UARTTXD = par_q;
`endif
            default:   UARTTXD = 1'b1;
        endcase
    end

    // Level field is 8 bits wide; a 256-deep FIFO saturates it when full
    assign level_x  = 9'(level);
    assign level_rd = level_x[8] ? 8'hFF : level_x[7:0];
    assign TXINTR   = ie_q & (level_x <= {1'b0, thresh_q});

    always_comb begin
        PRDATA = 16'd0;
        case (addr)
            ADDR_DIV: PRDATA = div_q;
            ADDR_CTRL: begin
                PRDATA[CTRL_THRESH_LSB +: 8] = thresh_q;
                PRDATA[CTRL_IE_BIT]          = ie_q;
`ifdef UART_TX_PARITY_EN
                PRDATA[CTRL_PAR_BIT]         = odd_q;
`endif
                PRDATA[CTRL_EN_BIT]          = en_q;
            end
            ADDR_STATUS: begin
                PRDATA[STAT_LEVEL_LSB +: 8]  = level_rd;
                PRDATA[STAT_OVF_BIT]         = ovf_q;
                PRDATA[STAT_FULL_BIT]        = full;
                PRDATA[STAT_EMPTY_BIT]       = empty;
                PRDATA[STAT_BUSY_BIT]        = busy;
            end
            default: PRDATA = 16'd0;
        endcase
    end

endmodule
`default_nettype wire
